// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, drives datapath enables and counts retirements.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic [1:0]       ALU_op,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_TRAP      = 4'd10
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t           state_r;
    state_t           next_state_s;
    logic             retire_s;
    logic [CNT_W-1:0] retired_r;
    logic             unused_s;

    // The branch outcome is applied in the datapath through pc_write_cond.
    assign unused_s = zero;
    assign retired  = retired_r;

    // Only the exact opcode/funct3 pairs of the supported subset are legal.
    function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
        state_t ns;
        case (op)
            OP_R:      ns = S_EXECUTE;
            OP_LOAD:   ns = (f3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
            OP_STORE:  ns = (f3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
            OP_BRANCH: ns = (f3 == 3'b000) ? S_BRANCH : S_TRAP;
            default:   ns = S_TRAP;
        endcase
        return ns;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state and Moore output decode; FETCH enables also wait for mem_ready.
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        ALU_op        = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        trap          = 1'b0;
        case (state_r)
            S_RESET: begin
                next_state_s = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = 2'b01;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB      = 2'b10;
                next_state_s = decode_next(opcode, funct3);
            end
            S_EXECUTE: begin
                ALUSrcA      = 1'b1;
                ALU_op       = 2'b10;
                next_state_s = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write    = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // DECODE only lets loads and stores reach this state.
                if (opcode == OP_LOAD) begin
                    next_state_s = S_MEM_READ;
                end else begin
                    next_state_s = S_MEM_WRITE;
                end
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else begin
                    next_state_s = S_MEM_READ;
                end
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire_s     = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_WRITE;
                end
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALU_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                retire_s      = 1'b1;
                next_state_s  = S_FETCH;
            end
            S_TRAP: begin
                trap         = 1'b1;
                next_state_s = S_TRAP;
            end
            default: begin
                next_state_s = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle output vectors
// and retirement counts for every instruction class, traps, reset and wrap.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'b0110011;
    logic [2:0]  funct3 = 3'b000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;

    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source;
    logic [1:0]  ALU_op, ALUSrcB;
    logic        ALUSrcA, reg_write, mem_to_reg, trap;
    logic [31:0] retired;

    logic        w_mem_read, w_mem_write, w_iord, w_ir_write, w_pc_write, w_pc_write_cond, w_pc_source;
    logic [1:0]  w_ALU_op, w_ALUSrcB;
    logic        w_ALUSrcA, w_reg_write, w_mem_to_reg, w_trap;
    logic [2:0]  w_retired;

    logic [14:0] ov;

    int checks = 0;
    int failures = 0;

    // Bit order: mem_read mem_write iord ir_write pc_write pc_write_cond pc_source
    //            ALU_op[1:0] ALUSrcA ALUSrcB[1:0] reg_write mem_to_reg trap
    localparam logic [14:0] V_RESET     = 15'b000000000000000;
    localparam logic [14:0] V_FETCH_RDY = 15'b100110000001000;
    localparam logic [14:0] V_FETCH_WT  = 15'b100000000001000;
    localparam logic [14:0] V_DECODE    = 15'b000000000010000;
    localparam logic [14:0] V_EXECUTE   = 15'b000000010100000;
    localparam logic [14:0] V_ALU_WB    = 15'b000000000000100;
    localparam logic [14:0] V_MEM_ADDR  = 15'b000000000110000;
    localparam logic [14:0] V_MEM_READ  = 15'b101000000000000;
    localparam logic [14:0] V_MEM_WB    = 15'b000000000000110;
    localparam logic [14:0] V_MEM_WRITE = 15'b011000000000000;
    localparam logic [14:0] V_BRANCH    = 15'b000001101100000;
    localparam logic [14:0] V_TRAP      = 15'b000000000000001;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .ALU_op(ALU_op), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap), .retired(retired)
    );

    // Narrow-counter copy so the wrap can be reached in a few instructions.
    multicycle_control #(.CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_read(w_mem_read), .mem_write(w_mem_write), .iord(w_iord),
        .ir_write(w_ir_write), .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond),
        .pc_source(w_pc_source), .ALU_op(w_ALU_op), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB),
        .reg_write(w_reg_write), .mem_to_reg(w_mem_to_reg), .trap(w_trap), .retired(w_retired)
    );

    assign ov = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                 ALU_op, ALUSrcA, ALUSrcB, reg_write, mem_to_reg, trap};

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive mem_ready on the falling edge, then sample outputs.
    task automatic cyc(input logic rdy, input logic [14:0] exp, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        #1;
        check_value(tag, {17'd0, ov}, {17'd0, exp});
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
    endtask

    task automatic r_type();
        set_instr(7'b0110011, 3'b000);
        cyc(1'b1, V_FETCH_RDY, "r_fetch");
        cyc(1'b1, V_DECODE, "r_decode");
        cyc(1'b1, V_EXECUTE, "r_execute");
        cyc(1'b1, V_ALU_WB, "r_alu_wb");
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("reset_state", {17'd0, ov}, {17'd0, V_RESET});
    endtask

    initial begin
        // Reset state
        #1;
        check_value("rst_outputs", {17'd0, ov}, 32'd0);
        check_value("rst_retired", retired, 32'd0);
        check_value("rst_trap", {31'd0, trap}, 32'd0);
        release_reset();

        // R-type, zero-wait: 4 cycles
        r_type();
        set_instr(7'b0000011, 3'b010);
        cyc(1'b1, V_FETCH_RDY, "lw_fetch");
        check_value("retired_after_r", retired, 32'd1);

        // lw with 3 wait cycles in MEM_READ: 8 cycles total
        cyc(1'b1, V_DECODE, "lw_decode");
        cyc(1'b1, V_MEM_ADDR, "lw_mem_addr");
        for (int i = 0; i < 3; i++) cyc(1'b0, V_MEM_READ, "lw_mem_read_wait");
        cyc(1'b1, V_MEM_READ, "lw_mem_read_done");
        cyc(1'b1, V_MEM_WB, "lw_mem_wb");

        // beq taken then not taken: 3 cycles each
        set_instr(7'b1100011, 3'b000);
        zero = 1'b1;
        cyc(1'b1, V_FETCH_RDY, "beq1_fetch");
        check_value("retired_after_lw", retired, 32'd2);
        cyc(1'b1, V_DECODE, "beq1_decode");
        cyc(1'b1, V_BRANCH, "beq1_branch");
        zero = 1'b0;
        cyc(1'b1, V_FETCH_RDY, "beq2_fetch");
        cyc(1'b1, V_DECODE, "beq2_decode");
        cyc(1'b1, V_BRANCH, "beq2_branch");

        // sw with 2 wait cycles in MEM_WRITE
        set_instr(7'b0100011, 3'b010);
        cyc(1'b1, V_FETCH_RDY, "sw_fetch");
        check_value("retired_after_beq", retired, 32'd4);
        cyc(1'b1, V_DECODE, "sw_decode");
        cyc(1'b1, V_MEM_ADDR, "sw_mem_addr");
        cyc(1'b0, V_MEM_WRITE, "sw_mem_write_wait");
        cyc(1'b0, V_MEM_WRITE, "sw_mem_write_wait");
        cyc(1'b1, V_MEM_WRITE, "sw_mem_write_done");

        // Illegal opcode with one fetch wait, then sticky TRAP
        set_instr(7'b1111111, 3'b000);
        cyc(1'b0, V_FETCH_WT, "ill_fetch_wait");
        check_value("retired_after_sw", retired, 32'd5);
        cyc(1'b1, V_FETCH_RDY, "ill_fetch");
        cyc(1'b1, V_DECODE, "ill_decode");
        for (int i = 0; i < 20; i++) cyc(i[0], V_TRAP, "ill_trap_hold");
        check_value("retired_after_illegal", retired, 32'd5);

        // Reset clears trap and the counter
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("trap_reset_outputs", {17'd0, ov}, 32'd0);
        check_value("trap_reset_retired", retired, 32'd0);
        release_reset();

        // lw opcode with a bad funct3 is illegal
        set_instr(7'b0000011, 3'b000);
        cyc(1'b1, V_FETCH_RDY, "badf3_fetch");
        cyc(1'b1, V_DECODE, "badf3_decode");
        cyc(1'b1, V_TRAP, "badf3_trap");
        cyc(1'b1, V_TRAP, "badf3_trap");
        check_value("badf3_retired", retired, 32'd0);

        @(negedge clk);
        rst_n = 1'b0;
        release_reset();

        // Asynchronous reset in the middle of a FETCH wait
        r_type();
        set_instr(7'b0110011, 3'b000);
        cyc(1'b0, V_FETCH_WT, "async_fetch_wait");
        check_value("async_pre_retired", retired, 32'd1);
        cyc(1'b0, V_FETCH_WT, "async_fetch_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_outputs", {17'd0, ov}, 32'd0);
        check_value("async_retired", retired, 32'd0);
        check_value("async_trap", {31'd0, trap}, 32'd0);
        release_reset();

        // Counter wrap on the 3-bit instance
        for (int i = 0; i < 7; i++) r_type();
        cyc(1'b1, V_FETCH_RDY, "wrap_fetch7");
        check_value("wrap_at_max", {29'd0, w_retired}, 32'd7);
        cyc(1'b1, V_DECODE, "wrap_decode");
        cyc(1'b1, V_EXECUTE, "wrap_execute");
        cyc(1'b1, V_ALU_WB, "wrap_alu_wb");
        cyc(1'b1, V_FETCH_RDY, "wrap_fetch8");
        check_value("wrap_to_zero", {29'd0, w_retired}, 32'd0);
        check_value("wide_count8", retired, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the sequential (multi-cycle) RV32I datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and the 2-bit `ALU_op` code consumed by `alu_control`, which turns `ALU_op`, `funct3` and `bit30` into `ALUControl`. It also handles the shared instruction/data memory handshake and counts retired instructions.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instruction register bits [6:0].
- `funct3`  in  3  instruction register bits [14:12].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  unconditional PC write.
- `pc_write_cond`  out  1  PC write gated by `zero`.
- `pc_source`  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- `ALU_op`  out  2  code for `alu_control`: 00 = add, 01 = sub, 10 = decode from funct3/bit30.
- `ALUSrcA`  out  1  ALU A input: 0 = PC, 1 = rs1.
- `ALUSrcB`  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = immediate.
- `reg_write`  out  1  register file write.
- `mem_to_reg`  out  1  register file write data: 0 = ALUOut, 1 = MDR.
- `trap`  out  1  illegal instruction seen; sticky.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Supported instructions: R-type (opcode 0110011), `lw` (0000011, funct3 010), `sw` (0100011, funct3 010), `beq` (1100011, funct3 000). Any other opcode/funct3 combination is illegal.
- Moore state register with asynchronous reset. Outputs are decoded from the state, except `ir_write` and `pc_write` in FETCH, which are additionally gated by `mem_ready`.
- Any output not listed for a state is 0 in that state.

States and outputs:
- RESET: all outputs 0. Goes to FETCH on the first clock edge after `rst_n` deasserts.
- FETCH: `mem_read`=1, `iord`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALU_op`=00, `pc_source`=0.
  - While `mem_ready`=0: hold in FETCH.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1 that cycle; go to DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=10, `ALU_op`=00 (computes the branch target into ALUOut).
  - Next state by opcode: R -> EXECUTE; lw/sw -> MEM_ADDR; beq -> BRANCH; illegal -> TRAP.
- EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALU_op`=10. Next: ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=0. Retire. Next: FETCH.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALU_op`=00. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_read`=1, `iord`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1. Retire. Next: FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1. Hold until `mem_ready`, then retire and go to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALU_op`=01, `pc_write_cond`=1, `pc_source`=1. Retire. Next: FETCH.
- TRAP: `trap`=1, all other outputs 0. Stays in TRAP until reset. Illegal instructions do not retire.

Counter and request rules:
- Retire means `retired` increments by 1 at the clock edge leaving that state.
- `retired` wraps modulo 2^CNT_W, with no saturation.
- `mem_read` and `mem_write` are never both 1.
- A request stays asserted with a stable `iord` until the cycle `mem_ready`=1.

## Timing
- At reset: state = RESET, all outputs 0, `retired`=0, `trap`=0.
- Reset takes effect immediately on `rst_n` falling, in any state, including mid-wait on memory. The pending request drops the same cycle.
- Cycle counts with zero-wait memory (`mem_ready` tied 1):
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle to FETCH, MEM_READ or MEM_WRITE.
- `mem_ready` is ignored in states that issue no request.
- `opcode` and `funct3` are sampled only in DECODE and MEM_ADDR. The instruction register holds them stable from the FETCH completion until the next FETCH.

## Test plan
- Reset, then release with `mem_ready`=1 and opcode 0110011. Required: state sequence RESET, FETCH, DECODE, EXECUTE, ALU_WB, FETCH; `ALU_op`=10 in EXECUTE; `reg_write`=1 only in ALU_WB; `retired`=1 afterwards.
- lw with `mem_ready` low for 3 cycles in MEM_READ. Required: `mem_read`=1 and `iord`=1 held for 4 cycles; `mem_to_reg`=1 and `reg_write`=1 in MEM_WB; total 8 cycles.
- beq with `zero`=1, then with `zero`=0. Required: `ALU_op`=01, `pc_write_cond`=1 and `pc_source`=1 in BRANCH in both cases; each instruction takes 3 cycles; `retired` advances by 2.
- sw, then an illegal opcode 1111111. Required: `mem_write`=1 until `mem_ready`; then after DECODE, `trap`=1 and all other outputs 0; state held in TRAP for 20 cycles; `retired` unchanged by the illegal instruction.
- Assert `rst_n` low during a FETCH wait. Required: all outputs 0 asynchronously, `retired`=0, `trap` cleared.
- Force `retired` = 2^CNT_W-1 and retire one R-type. Required: `retired` wraps to 0.
